// File: rtl/spi_master_fifo_if.sv
// CPU-side register bus for the buffered SPI master.
// The I/O decode drives the strobes; the SPI block returns read data.
interface spi_master_fifo_if;
    logic        cs;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rd;
    logic [31:0] rdata;

    modport master (output cs, addr, wdata, wstrb, rd, input rdata);
    modport slave  (input cs, addr, wdata, wstrb, rd, output rdata);
endinterface

// File: rtl/spi_master_fifo.sv
// Memory-mapped SPI master, mode 0, 8-bit MSB first.
// Separate TX and RX byte FIFOs with a level interrupt on RX data.
module spi_master_fifo #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] DIV_RESET  = 8'd7
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_fifo_if.slave  bus,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [1:0]        ss,
    output logic              irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

    state_t        state;
    logic [7:0]    tx_mem [FIFO_DEPTH];
    logic [7:0]    rx_mem [FIFO_DEPTH];
    logic [AW-1:0] tx_rd, tx_wr, rx_rd, rx_wr;
    logic [AW:0]   tx_cnt, rx_cnt;
    logic [7:0]    divider, divcnt, shift_tx, shift_rx;
    logic [3:0]    bitcnt;
    logic          irqen, overrun, busy;

    logic wr, rd_en, tx_full, tx_empty, rx_full, rx_empty;
    logic fall, done, start;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic unused;

    assign wr       = bus.cs & (|bus.wstrb);
    assign rd_en    = bus.cs & bus.rd & (bus.wstrb == 4'h0);
    assign tx_full  = (tx_cnt == FULL);
    assign tx_empty = (tx_cnt == '0);
    assign rx_full  = (rx_cnt == FULL);
    assign rx_empty = (rx_cnt == '0);

    assign fall  = (state == SHIFT) && (divcnt == divider) && sck;
    assign done  = fall && (bitcnt == 4'd1);
    assign start = !tx_empty && ((state == IDLE) || done);

    // A load frees a TX slot, so a write in that cycle fits even when full.
    assign tx_pop  = start;
    assign tx_push = wr && (bus.addr == 2'd0) && (!tx_full || tx_pop);
    assign rx_pop  = rd_en && (bus.addr == 2'd0) && !rx_empty;
    assign rx_push = done && (!rx_full || rx_pop);

    assign unused = ^{bus.wdata[30:17], bus.wdata[15:8]};

    always_comb begin
        bus.rdata = 32'h0;
        unique case (bus.addr)
            2'd0: bus.rdata = {24'h0, rx_empty ? 8'h00 : rx_mem[rx_rd]};
            2'd1: bus.rdata = {15'h0, irqen, divider, 3'b000, overrun,
                               rx_empty, tx_empty, tx_full, busy};
            2'd2: bus.rdata = {30'h0, ss};
            default: bus.rdata = 32'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= bus.wdata[7:0];
        if (rx_push) rx_mem[rx_wr] <= shift_rx;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_rd  <= '0;
            tx_wr  <= '0;
            tx_cnt <= '0;
            rx_rd  <= '0;
            rx_wr  <= '0;
            rx_cnt <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            tx_cnt <= tx_cnt + {{AW{1'b0}}, tx_push} - {{AW{1'b0}}, tx_pop};
            rx_cnt <= rx_cnt + {{AW{1'b0}}, rx_push} - {{AW{1'b0}}, rx_pop};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            divider <= DIV_RESET;
            irqen   <= 1'b0;
            overrun <= 1'b0;
            ss      <= 2'b11;
            irq     <= 1'b0;
        end else begin
            irq <= irqen & ~rx_empty;
            if (wr && (bus.addr == 2'd1)) begin
                divider <= bus.wdata[7:0];
                irqen   <= bus.wdata[16];
                if (bus.wdata[31]) overrun <= 1'b0;
            end
            if (wr && (bus.addr == 2'd2)) ss <= bus.wdata[1:0];
            if (done && rx_full && !rx_pop) overrun <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            sck      <= 1'b0;
            mosi     <= 1'b0;
            busy     <= 1'b0;
            shift_tx <= '0;
            shift_rx <= '0;
            bitcnt   <= '0;
            divcnt   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    sck  <= 1'b0;
                    mosi <= 1'b0;
                end
                LOAD: state <= SHIFT;
                SHIFT: begin
                    if (divcnt == divider) begin
                        divcnt <= '0;
                        sck    <= ~sck;
                        if (!sck) begin
                            shift_rx <= {shift_rx[6:0], miso};
                        end else begin
                            shift_tx <= {shift_tx[6:0], 1'b0};
                            mosi     <= shift_tx[6];
                            bitcnt   <= bitcnt - 1'b1;
                            if (bitcnt == 4'd1) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                mosi  <= 1'b0;
                            end
                        end
                    end else begin
                        divcnt <= divcnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Loading overrides the idle/end-of-byte defaults above.
            if (start) begin
                state    <= LOAD;
                shift_tx <= tx_mem[tx_rd];
                mosi     <= tx_mem[tx_rd][7];
                shift_rx <= '0;
                bitcnt   <= 4'd8;
                divcnt   <= '0;
                busy     <= 1'b1;
            end
        end
    end
endmodule

// File: doc/spi_master_fifo.md
Name: spi_master_fifo

Overview:
Memory-mapped SPI master (mode 0, 8-bit, MSB first) with TX and RX FIFOs. It replaces the inline, unbuffered SPI FSMs in the system top level. It sits downstream of the CPU I/O decode, which supplies a per-instance chip-select and a word offset, and it drives the SPI pins directly. The FIFOs let firmware queue multi-byte bursts without polling busy between bytes, and the level interrupt feeds the system IRQ vector table.

Parameters:
FIFO_DEPTH, 4, entries per FIFO (TX and RX each); power of 2, minimum 2.
DIV_RESET, 7, reset value of the clock divider field.

Ports:
clk  input  1  system clock (cclk).
reset  input  1  asynchronous, active-high reset.
cs  input  1  instance selected by I/O decode.
addr  input  2  word offset: 0=DAT, 1=CTL/STAT, 2=SS, 3=reserved.
wdata  input  32  CPU write data.
wstrb  input  4  byte write lanes; a write is cs & |wstrb.
rd  input  1  read strobe; a read is cs & rd & (wstrb==0).
rdata  output  32  combinational read data for the current addr.
sck  output  1  SPI clock, idle low.
mosi  output  1  SPI data out.
miso  input  1  SPI data in.
ss  output  2  slave selects, software controlled, active low.
irq  output  1  level interrupt.

Behaviour:
Reset values: sck=0, mosi=0, ss=2'b11, irq=0, divider=DIV_RESET, irqen=0, both FIFOs empty, busy=0, overrun=0.

Register map:
- Write DAT: pushes wdata[7:0] into the TX FIFO. If the TX FIFO is full, the write is dropped with no state change.
- Read DAT: returns {24'h0, RX head}. A read pops the RX FIFO on that clock edge. If the RX FIFO is empty, rdata=0 and nothing is popped.
- Write CTL: divider<=wdata[7:0], irqen<=wdata[16]. If wdata[31]=1, overrun is cleared.
- Read CTL/STAT: {15'h0, irqen, divider[7:0], 3'b0, overrun, rxempty, txempty, txfull, busy}. Bit 0=busy, bit 1=txfull, bit 2=txempty, bit 3=rxempty, bit 4=overrun, bits 15:8=divider, bit 16=irqen.
- Write SS: ss<=wdata[1:0]. ss never changes automatically.
- Read SS: {30'h0, ss}.
- addr 3: reads 0; writes are ignored.

FSM states: IDLE, LOAD, SHIFT.
- IDLE: sck=0, mosi=0. If TX not empty, go to LOAD.
- LOAD (one cycle): pop TX head into shift_tx, clear shift_rx, bitcnt=8, divcnt=0, sck=0, busy=1, then go to SHIFT. mosi=shift_tx[7] from this cycle.
- SHIFT: divcnt counts 0..divider. At divcnt==divider, divcnt resets to 0 and sck toggles.
  - Rising edge (sck 0->1): shift_rx<={shift_rx[6:0],miso}.
  - Falling edge (sck 1->0): shift_tx shifts left and bitcnt decrements. At bitcnt 1->0, push shift_rx to the RX FIFO.
  - After the 8th falling edge: if TX is not empty, go to LOAD (busy stays 1). Otherwise go to IDLE with busy=0.
- Half-period is divider+1 clocks. One byte occupies 1 + 16*(divider+1) clocks from LOAD through the last falling edge.
- divider is sampled live. A change mid-byte applies from the next half-period compare.

Boundary conditions:
- RX full at byte completion: the byte is dropped and overrun=1 (sticky until cleared via CTL bit 31). The transfer continues.
- A CPU pop and a byte completion in the same cycle on a full RX FIFO: the push succeeds and no overrun is set.
- A CPU write to DAT in the same cycle as a LOAD pop on a full TX FIFO: the write is accepted.
- Pointers wrap modulo FIFO_DEPTH. Occupancy counters are log2(FIFO_DEPTH)+1 bits.
- irq = irqen & ~rxempty, registered (one cycle after the RX state change).
- Reset asserted mid-transfer: all state returns to reset values immediately (sck low asynchronously). The partial byte is discarded.

Test Plan:
1. divider=0, miso tied to mosi, write DAT=0xA5 -> LOAD next cycle; 8 sck pulses of period 2 clk; busy high for 17 cycles; read DAT=0x000000A5; rxempty then 1.
2. divider=3, write 0x3C, 0xC3, 0xFF back-to-back -> bytes go out contiguously with exactly one LOAD cycle (sck low) between them; sck half-period 4 clk; RX returns 3C, C3, FF in order.
3. FIFO_DEPTH=4, busy idle, write 6 bytes while divider=255 -> the first byte is loaded at once, 4 more are queued, the 6th is dropped; txfull=1 after the 5th write; exactly 5 bytes are transferred.
4. Transfer 5 bytes without reading RX -> 4 bytes are stored, overrun=1; write CTL with bit31=1 and divider unchanged -> overrun=0; the RX contents are intact.
5. irqen=1, send one byte -> irq rises the cycle after the RX push; read DAT -> irq falls the cycle after the pop; read of an empty DAT returns 0.
6. Assert reset during the 4th bit with ss=2'b10 -> sck=0, mosi=0, ss=2'b11, busy=0, FIFOs empty, divider=7, all within the same cycle.
